gray_seq_checker: RTL and testbench
===================================

// Module: gray_seq_checker
// PURPOSE
//  - Receive end of the Gray counter interface. Samples a W-bit Gray word, decodes it to binary,
//    and checks that consecutive samples form a legal Gray sequence (hold or +1 step, with wrap).
//  - Reports lock status, a per-sample error pulse and a saturating error count.
//  - Sits downstream of grcntr (gr bus) and feeds status/monitor logic.
// PARAMETERS
//  W         4  Gray/binary word width
//  LOCK_CNT  3  consecutive legal +1 steps needed (after first sample) to assert locked; >=1
//  ERR_W     8  width of error counter
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      asynchronous, active-high reset
//  gr_in      in   W      Gray-coded input word
//  gr_valid   in   1      gr_in is a new sample this cycle
//  clr_err    in   1      synchronous clear of err_cnt
//  bin_out    out  W      registered binary decode of last valid sample
//  bin_valid  out  1      1-cycle pulse: bin_out updated
//  locked     out  1      sequence tracking is locked
//  step_err   out  1      1-cycle pulse, aligned with bin_valid: sample was illegal
//  err_cnt    out  ERR_W  count of illegal samples, saturates at all-ones
// BEHAVIOUR
//  - Reset: bin_out=0, bin_valid=0, locked=0, step_err=0, err_cnt=0, good_cnt=0, prev_bin=0, state=EMPTY.
//  - Latency: one clock. gr_valid at edge N -> bin_out/bin_valid/step_err/locked updated at edge N.
//  - gr_valid=0: bin_valid=0, step_err=0; all other state held (err_cnt still honours clr_err).
//  - Decode: b[W-1]=g[W-1]; b[i]=b[i+1]^g[i]. Compare new binary d against prev_bin:
//      HOLD d==prev_bin; STEP d==(prev_bin+1) mod 2^W (incl. 2^W-1 -> 0); BAD otherwise.
//  - Every valid sample updates prev_bin and bin_out, including BAD samples (resync to new value).
//  - FSM states (shared package):
//      EMPTY : first valid sample -> ACQ, good_cnt=0, no classification, step_err=0.
//      ACQ   : STEP -> good_cnt+1; if result == LOCK_CNT -> LOCKED (locked=1 same edge).
//              HOLD -> no change. BAD -> stay ACQ, good_cnt=0, step_err=1.
//      LOCKED: STEP/HOLD -> stay. BAD -> ACQ, good_cnt=0, locked=0, step_err=1 same edge.
//  - good_cnt width $clog2(LOCK_CNT+1); never exceeds LOCK_CNT.
//  - err_cnt: +1 on each step_err; saturates at 2^ERR_W-1.
//      clr_err alone -> 0. clr_err with BAD in the same cycle -> 1 (clear first, then count).
//  - Async rst mid-operation: all outputs to reset values immediately; next sample treated as EMPTY.
// STRUCTURE
//  - Package grcntr_pkg: FSM state localparams (EMPTY=2'd0, ACQ=2'd1, LOCKED=2'd2),
//    gray2bin/bin2gray functions shared with grcntr and benches.
//  - Sub-module gray2bin (combinational, param W) instantiated once; the FSM, counters and
//    registers live in gray_seq_checker.
// TESTING
//  1. rst=1 for 2 cycles, gr_valid=0 -> all outputs 0; locked=0.
//  2. Feed Gray 0..15 (0000,0001,0011,...,1000) one per cycle -> bin_out 0..15 with bin_valid each
//     cycle; locked=1 at the edge of the 4th sample (bin 3); step_err never 1.
//  3. Continue 1000 -> 0000 (wrap) -> bin_out=0, no step_err, locked stays 1.
//  4. While locked at bin 3 (0010), inject Gray 0111 (bin 5) -> step_err=1 one cycle, err_cnt=1,
//     locked=0; then 0101 (bin 6), 0100, 1100 -> locked=1 again after 3rd legal step.
//  5. Repeat same Gray word 5 times -> HOLD: no step_err, lock state unchanged; gap gr_valid=0 ->
//     bin_valid=0, bin_out held.
//  6. ERR_W=2: 4 BAD samples -> err_cnt 1,2,3,3; clr_err with BAD same cycle -> 1; rst asserted
//     mid-sequence -> immediate zeros, next sample gives bin_valid, no step_err.

Source files
------------

// File: rtl/grcntr_pkg.sv
// Shared definitions for the Gray counter link: tracker FSM states and
// width-agnostic Gray/binary conversion helpers.
package grcntr_pkg;

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    ACQ    = 2'd1,
    LOCKED = 2'd2
  } state_e;

  // Words narrower than 32 bits are zero-extended; the upper zeros do not
  // disturb the prefix XOR of the low bits.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/gray2bin.sv
// Combinational Gray-to-binary decode: each binary bit is the XOR of all
// Gray bits at or above it.
module gray2bin #(
  parameter int W = 4
) (
  input  logic [W-1:0] g,
  output logic [W-1:0] b
);

  for (genvar i = 0; i < W; i++) begin : g_bit
    assign b[i] = ^g[W-1:i];
  end

endmodule

// File: rtl/gray_seq_checker.sv
// Receive-side Gray sequence tracker: decodes each valid sample, classifies it
// against the previous one (hold / +1 / bad), tracks lock and counts errors.
module gray_seq_checker
  import grcntr_pkg::*;
#(
  parameter int W        = 4,
  parameter int LOCK_CNT = 3,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [W-1:0]     gr_in,
  input  logic             gr_valid,
  input  logic             clr_err,
  output logic [W-1:0]     bin_out,
  output logic             bin_valid,
  output logic             locked,
  output logic             step_err,
  output logic [ERR_W-1:0] err_cnt
);

  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam logic [GW-1:0] LOCK_V = GW'(LOCK_CNT);

  state_e           state, state_n;
  logic [GW-1:0]    good_cnt, good_n;
  logic [W-1:0]     prev_bin, d;
  logic             locked_n, bad;
  logic             is_hold, is_step;
  logic [ERR_W-1:0] err_base, err_n;

  gray2bin #(.W(W)) u_dec (
    .g (gr_in),
    .b (d)
  );

  assign is_hold = (d == prev_bin);
  assign is_step = (d == prev_bin + 1'b1);
  assign bin_out = prev_bin;

  always_comb begin
    state_n  = state;
    good_n   = good_cnt;
    locked_n = locked;
    bad      = 1'b0;
    if (gr_valid) begin
      unique case (state)
        EMPTY: begin
          state_n = ACQ;
          good_n  = '0;
        end
        ACQ: begin
          if (is_step) begin
            good_n = good_cnt + 1'b1;
            if (good_cnt + 1'b1 == LOCK_V) begin
              state_n  = LOCKED;
              locked_n = 1'b1;
            end
          end else if (!is_hold) begin
            bad    = 1'b1;
            good_n = '0;
          end
        end
        LOCKED: begin
          if (!is_step && !is_hold) begin
            bad      = 1'b1;
            state_n  = ACQ;
            good_n   = '0;
            locked_n = 1'b0;
          end
        end
        default: begin
          state_n  = EMPTY;
          good_n   = '0;
          locked_n = 1'b0;
        end
      endcase
    end
  end

  // Clear takes effect before the increment so clear+bad lands on 1.
  always_comb begin
    err_base = clr_err ? '0 : err_cnt;
    err_n    = err_base;
    if (bad && (err_base != '1)) err_n = err_base + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= EMPTY;
      good_cnt  <= '0;
      prev_bin  <= '0;
      locked    <= 1'b0;
      bin_valid <= 1'b0;
      step_err  <= 1'b0;
      err_cnt   <= '0;
    end else begin
      state     <= state_n;
      good_cnt  <= good_n;
      locked    <= locked_n;
      bin_valid <= gr_valid;
      step_err  <= bad;
      err_cnt   <= err_n;
      if (gr_valid) prev_bin <= d;
    end
  end

endmodule

// File: tb/tb_gray_seq_checker.sv
// Randomized and directed bench for gray_seq_checker; two instances (ERR_W=8
// and ERR_W=2) share stimulus and are checked against one sequence model.
module tb_gray_seq_checker;

  logic       clk, rst;
  logic [3:0] gr_in;
  logic       gr_valid, clr_err;
  logic [3:0] bin_out, bin_out2;
  logic       bin_valid, locked, step_err;
  logic       bin_valid2, locked2, step_err2;
  logic [7:0] err_cnt;
  logic [1:0] err_cnt2;

  gray_seq_checker #(.W(4), .LOCK_CNT(3), .ERR_W(8)) dut (
    .clk(clk), .rst(rst), .gr_in(gr_in), .gr_valid(gr_valid), .clr_err(clr_err),
    .bin_out(bin_out), .bin_valid(bin_valid), .locked(locked),
    .step_err(step_err), .err_cnt(err_cnt)
  );

  gray_seq_checker #(.W(4), .LOCK_CNT(3), .ERR_W(2)) dut2 (
    .clk(clk), .rst(rst), .gr_in(gr_in), .gr_valid(gr_valid), .clr_err(clr_err),
    .bin_out(bin_out2), .bin_valid(bin_valid2), .locked(locked2),
    .step_err(step_err2), .err_cnt(err_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: previous value, whether a first sample was seen, the
  // run of +1 steps since lock was lost, and plain integer error tallies.
  int m_prev, m_run, m_e8, m_e2;
  bit m_started, m_locked, m_valid, m_err;

  function automatic int g2b(input logic [3:0] g);
    return int'(g ^ (g >> 1) ^ (g >> 2) ^ (g >> 3));
  endfunction

  function automatic logic [3:0] b2g(input int b);
    logic [3:0] v;
    v = 4'(b);
    return v ^ (v >> 1);
  endfunction

  function automatic logic [23:0] obs();
    return {bin_out, bin_valid, locked, step_err, err_cnt,
            bin_out2, bin_valid2, locked2, step_err2, err_cnt2};
  endfunction

  function automatic logic [23:0] expv();
    return {4'(m_prev), m_valid, m_locked, m_err, 8'(m_e8),
            4'(m_prev), m_valid, m_locked, m_err, 2'(m_e2)};
  endfunction

  task automatic model_reset();
    m_prev = 0; m_run = 0; m_e8 = 0; m_e2 = 0;
    m_started = 0; m_locked = 0; m_valid = 0; m_err = 0;
  endtask

  // Drive one cycle of stimulus, advance past the edge, update the model.
  task automatic drive(input bit v, input logic [3:0] g, input bit clr);
    int d;
    gr_valid = v; gr_in = g; clr_err = clr;
    @(posedge clk); #1;
    m_valid = v;
    m_err   = 0;
    if (v) begin
      d = g2b(g);
      if (!m_started) begin
        m_started = 1;
        m_run = 0;
      end else if (d == m_prev) begin
      end else if (d == (m_prev + 1) % 16) begin
        if (!m_locked) begin
          m_run++;
          if (m_run == 3) m_locked = 1;
        end
      end else begin
        m_err = 1; m_run = 0; m_locked = 0;
      end
      m_prev = d;
    end
    if (clr) begin m_e8 = 0; m_e2 = 0; end
    if (m_err) begin
      if (m_e8 < 255) m_e8++;
      if (m_e2 < 3) m_e2++;
    end
  endtask

  task automatic test_reset();
    rst = 1; gr_valid = 0; gr_in = '0; clr_err = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (obs() !== 24'h0) begin
      miscompares++;
      $display("FAIL reset: got %h want %h", obs(), 24'h0);
    end
    rst = 0;
  endtask

  task automatic test_count();
    for (int i = 0; i < 16; i++) begin
      drive(1, b2g(i), 0);
      vectors++;
      if (obs() !== expv()) begin
        miscompares++;
        $display("FAIL count[%0d]: got %h want %h", i, obs(), expv());
      end
      vectors++;
      if (locked !== (i >= 3)) begin
        miscompares++;
        $display("FAIL lock_point[%0d]: got %b want %b", i, locked, (i >= 3));
      end
    end
  endtask

  task automatic test_wrap();
    drive(1, 4'b0000, 0);
    vectors++;
    if (obs() !== expv() || bin_out !== 4'd0 || step_err !== 1'b0 || locked !== 1'b1) begin
      miscompares++;
      $display("FAIL wrap: got %h want %h", obs(), expv());
    end
  endtask

  task automatic test_relock();
    logic [3:0] seq [7];
    seq = '{4'b0001, 4'b0011, 4'b0010, 4'b0111, 4'b0101, 4'b0100, 4'b1100};
    for (int i = 0; i < 7; i++) begin
      drive(1, seq[i], 0);
      vectors++;
      if (obs() !== expv()) begin
        miscompares++;
        $display("FAIL relock[%0d]: got %h want %h", i, obs(), expv());
      end
      if (i == 3) begin
        vectors++;
        if ({step_err, locked, err_cnt} !== {1'b1, 1'b0, 8'd1}) begin
          miscompares++;
          $display("FAIL inject: got err=%b lk=%b cnt=%0d want 1 0 1", step_err, locked, err_cnt);
        end
      end
    end
    vectors++;
    if (locked !== 1'b1 || bin_out !== 4'd8) begin
      miscompares++;
      $display("FAIL relocked: got lk=%b bin=%0d want 1 8", locked, bin_out);
    end
  endtask

  task automatic test_hold();
    for (int i = 0; i < 8; i++) begin
      drive(i < 5, (i < 5) ? 4'b1100 : 4'($urandom_range(15)), 0);
      vectors++;
      if (obs() !== expv()) begin
        miscompares++;
        $display("FAIL hold[%0d]: got %h want %h", i, obs(), expv());
      end
    end
  endtask

  task automatic test_saturate();
    logic [3:0] seq [5];
    seq = '{4'b0000, 4'b1100, 4'b0000, 4'b1100, 4'b0000};
    drive(0, 4'b0000, 1);
    vectors++;
    if (obs() !== expv() || err_cnt2 !== 2'd0) begin
      miscompares++;
      $display("FAIL clr_alone: got %h want %h", obs(), expv());
    end
    for (int i = 0; i < 5; i++) begin
      drive(1, seq[i], i == 4);
      vectors++;
      if (obs() !== expv()) begin
        miscompares++;
        $display("FAIL sat[%0d]: got %h want %h", i, obs(), expv());
      end
    end
    vectors++;
    if (err_cnt2 !== 2'd1 || err_cnt !== 8'd1) begin
      miscompares++;
      $display("FAIL clr_with_bad: got %0d/%0d want 1/1", err_cnt, err_cnt2);
    end
  endtask

  task automatic test_async_rst();
    drive(1, 4'b0110, 0);
    #3 rst = 1;
    #1;
    model_reset();
    vectors++;
    if (obs() !== 24'h0) begin
      miscompares++;
      $display("FAIL async_rst: got %h want %h", obs(), 24'h0);
    end
    #1 rst = 0;
    drive(1, 4'b1010, 0);
    vectors++;
    if (obs() !== expv() || bin_valid !== 1'b1 || step_err !== 1'b0) begin
      miscompares++;
      $display("FAIL post_rst: got %h want %h", obs(), expv());
    end
  endtask

  task automatic test_random();
    int r, nb;
    for (int i = 0; i < 400; i++) begin
      r = int'($urandom_range(99));
      nb = (r < 65) ? m_prev + 1 : (r < 80) ? m_prev : int'($urandom_range(15));
      drive($urandom_range(9) < 8, b2g(nb), $urandom_range(19) == 0);
      vectors++;
      if (obs() !== expv()) begin
        miscompares++;
        $display("FAIL random[%0d]: got %h want %h", i, obs(), expv());
      end
    end
  endtask

  initial begin
    test_reset();
    test_count();
    test_wrap();
    test_relock();
    test_hold();
    test_saturate();
    test_async_rst();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
